// File: rtl/seq_alu_core.sv
`default_nettype none
// ============================================================================
// Module   : seq_alu_core
// Purpose  : Registered ALU with the legacy 16-entry ctrl/cin function table,
//            extended ops (ROL, ROR, ASR) and an iterative N-cycle unsigned
//            shift-add multiplier. Single-cycle ops complete on the accepting
//            edge; MUL holds busy for N cycles and then pulses done.
// Ports    : clk      - rising-edge clock
//            rst      - asynchronous active-high reset
//            i_start  - operation request, accepted when o_busy=0
//            i_a/i_b  - operands, captured on accept
//            i_cin    - carry in / variant select, captured on accept
//            i_ctrl   - operation select, captured on accept
//            o_f      - result (low half of the product for MUL)
//            o_f_hi   - high half of the product for MUL, else 0
//            o_cout   - adder carry out (ctrl=0000 only)
//            o_v      - signed overflow (ctrl=0000 only)
//            o_z/o_n  - zero / sign flags of the result
//            o_busy   - multiply in progress
//            o_done   - one-cycle pulse: results valid for the completed op
// Revision : 1.0 - initial release
// ============================================================================
module seq_alu_core #(
   parameter int N = 8,
   parameter int M = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_start,
   input  logic [N-1:0] i_a,
   input  logic [N-1:0] i_b,
   input  logic         i_cin,
   input  logic [3:0]   i_ctrl,
   output logic [N-1:0] o_f,
   output logic [N-1:0] o_f_hi,
   output logic         o_cout,
   output logic         o_v,
   output logic         o_z,
   output logic         o_n,
   output logic         o_busy,
   output logic         o_done
);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_MUL  = 1'b1
   } state_t;

   // Counter value on the final shift-add step (N = 2**M, so N-1 fits in M bits)
   localparam logic [M-1:0] c_LAST = M'(N - 1);

   state_t           r_state;
   logic [M-1:0]     r_cnt;
   logic [2*N-1:0]   r_mcand;
   logic [N-1:0]     r_mplier;
   logic [2*N-1:0]   r_acc;
   logic [N-1:0]     r_f;
   logic [N-1:0]     r_f_hi;
   logic             r_cout;
   logic             r_v;
   logic             r_z;
   logic             r_n;
   logic             r_busy;
   logic             r_done;

   logic [N-1:0]     w_bb;
   logic [N:0]       w_sum;
   logic             w_c_msb;
   logic [M-1:0]     w_amt;
   logic [2*N-1:0]   w_dbl;
   logic [N-1:0]     w_rol;
   logic [N-1:0]     w_ror;
   logic [N-1:0]     w_asr;
   logic [N-1:0]     w_res;
   logic             w_cout;
   logic             w_v;
   logic             w_is_mul;
   logic [2*N-1:0]   w_acc_next;

   // ------------------------------------------------------------------------
   // Single-cycle datapath, evaluated directly from the inputs so the result
   // can be registered on the accepting edge.
   // ------------------------------------------------------------------------
   always_comb begin
      w_bb    = i_cin ? ~i_b : i_b;
      w_sum   = {1'b0, i_a} + {1'b0, w_bb} + {{N{1'b0}}, i_cin};
      // Carry into the MSB recovered from the sum bit: s = a ^ b ^ c
      w_c_msb = w_sum[N-1] ^ i_a[N-1] ^ w_bb[N-1];
      w_amt   = i_b[M-1:0];
      w_dbl   = {i_a, i_a};
      // Rotates via a doubled operand; a shift of N (amount 0) yields i_a
      w_rol   = N'(w_dbl >> (N - int'(w_amt)));
      w_ror   = N'(w_dbl >> w_amt);
      w_asr   = N'($signed(i_a) >>> w_amt);
      w_is_mul = (i_ctrl == 4'b1000) && !i_cin;

      w_res  = '0;
      w_cout = 1'b0;
      w_v    = 1'b0;
      if (!i_ctrl[3]) begin
         case (i_ctrl[2:0])
            3'b000: begin
               w_res  = w_sum[N-1:0];
               w_cout = w_sum[N];
               w_v    = w_c_msb ^ w_sum[N];
            end
            3'b001, 3'b101: w_res = i_a | w_bb;
            3'b010, 3'b110: w_res = i_a & w_bb;
            3'b011:         w_res = i_cin ? ~i_b : ~i_a;
            3'b100:         w_res = i_cin ? (i_a >> w_amt) : (i_a << w_amt);
            3'b111:         w_res = i_cin ? i_b : i_a;
            default:        w_res = '0;
         endcase
      end else begin
         case ({i_ctrl[2:0], i_cin})
            4'b000_1: w_res = w_rol;
            4'b001_0: w_res = w_ror;
            4'b001_1: w_res = w_asr;
            default:  w_res = '0;
         endcase
      end
   end

   // One shift-add step: add the shifted multiplicand when the current
   // multiplier LSB is set.
   always_comb begin
      w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
   end

   // ------------------------------------------------------------------------
   // Control FSM with registered results and flags
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_acc    <= '0;
         r_f      <= '0;
         r_f_hi   <= '0;
         r_cout   <= 1'b0;
         r_v      <= 1'b0;
         r_z      <= 1'b0;
         r_n      <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  if (w_is_mul) begin
                     r_mcand  <= {{N{1'b0}}, i_a};
                     r_mplier <= i_b;
                     r_acc    <= '0;
                     r_cnt    <= '0;
                     r_busy   <= 1'b1;
                     r_state  <= S_MUL;
                  end else begin
                     r_f    <= w_res;
                     r_f_hi <= '0;
                     r_cout <= w_cout;
                     r_v    <= w_v;
                     r_z    <= (w_res == '0);
                     r_n    <= w_res[N-1];
                     r_done <= 1'b1;
                  end
               end
            end
            S_MUL: begin
               // i_start is not looked at here: requests while busy are dropped
               r_acc    <= w_acc_next;
               r_mcand  <= r_mcand << 1;
               r_mplier <= r_mplier >> 1;
               r_cnt    <= r_cnt + 1'b1;
               if (r_cnt == c_LAST) begin
                  r_f     <= w_acc_next[N-1:0];
                  r_f_hi  <= w_acc_next[2*N-1:N];
                  r_cout  <= 1'b0;
                  r_v     <= 1'b0;
                  r_z     <= (w_acc_next == '0);
                  r_n     <= w_acc_next[2*N-1];
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_cnt   <= '0;
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_f    = r_f;
   assign o_f_hi = r_f_hi;
   assign o_cout = r_cout;
   assign o_v    = r_v;
   assign o_z    = r_z;
   assign o_n    = r_n;
   assign o_busy = r_busy;
   assign o_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_seq_alu_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_alu_core
// Purpose  : Scoreboard testbench for seq_alu_core. Stimulus pushes the
//            expected response of every accepted op into a queue; a monitor
//            pops and compares whenever the DUT raises done.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_alu_core;

   localparam int N = 8;
   localparam int M = 3;

   typedef struct packed {
      logic [N-1:0] f;
      logic [N-1:0] fhi;
      logic         cout;
      logic         v;
      logic         z;
      logic         n;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         i_start;
   logic [N-1:0] i_a;
   logic [N-1:0] i_b;
   logic         i_cin;
   logic [3:0]   i_ctrl;
   logic [N-1:0] o_f;
   logic [N-1:0] o_f_hi;
   logic         o_cout;
   logic         o_v;
   logic         o_z;
   logic         o_n;
   logic         o_busy;
   logic         o_done;

   int   checks = 0;
   int   errors = 0;
   exp_t q[$];

   seq_alu_core #(.N(N), .M(M)) dut (
      .clk(clk), .rst(rst), .i_start(i_start), .i_a(i_a), .i_b(i_b),
      .i_cin(i_cin), .i_ctrl(i_ctrl), .o_f(o_f), .o_f_hi(o_f_hi),
      .o_cout(o_cout), .o_v(o_v), .o_z(o_z), .o_n(o_n),
      .o_busy(o_busy), .o_done(o_done)
   );

   always #5 clk = ~clk;

   // Reference model: arithmetic on integers, shifts/rotates as bit loops
   function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b,
                                  input logic cin, input logic [3:0] ctrl);
      exp_t         e;
      int           amt;
      int           ua, ub, sum, sa, sb, sr;
      int unsigned  prod, sh;
      logic [N-1:0] x;
      e   = '0;
      amt = int'(b) % N;
      x   = a;
      if (ctrl == 4'b0000) begin
         ua  = int'(a);
         ub  = cin ? ((1 << N) - 1 - int'(b)) : int'(b);
         sum = ua + ub + (cin ? 1 : 0);
         e.f = sum[N-1:0];
         e.cout = (sum >= (1 << N));
         sa = a[N-1] ? int'(a) - (1 << N) : int'(a);
         sb = b[N-1] ? int'(b) - (1 << N) : int'(b);
         sr = cin ? sa - sb : sa + sb;
         e.v = (sr > (1 << (N-1)) - 1) || (sr < -(1 << (N-1)));
      end else if (!ctrl[3]) begin
         case (ctrl[2:0])
            3'b001, 3'b101: e.f = a | (cin ? ~b : b);
            3'b010, 3'b110: e.f = a & (cin ? ~b : b);
            3'b011:         e.f = cin ? ~b : ~a;
            3'b100: begin
               sh  = cin ? (int'(a) >> amt) : ((int'(a) << amt) % (1 << N));
               e.f = sh[N-1:0];
            end
            3'b111:         e.f = cin ? b : a;
            default:        e.f = '0;
         endcase
      end else if (ctrl == 4'b1000 && !cin) begin
         prod  = int'(a) * int'(b);
         e.f   = prod[N-1:0];
         e.fhi = prod[2*N-1:N];
      end else if (ctrl == 4'b1000) begin
         for (int i = 0; i < amt; i++) x = {x[N-2:0], x[N-1]};
         e.f = x;
      end else if (ctrl == 4'b1001) begin
         for (int i = 0; i < amt; i++)
            x = cin ? {x[N-1], x[N-1:1]} : {x[0], x[N-1:1]};
         e.f = x;
      end
      if (ctrl == 4'b1000 && !cin) begin
         e.z = ({e.fhi, e.f} == '0);
         e.n = e.fhi[N-1];
      end else begin
         e.z = (e.f == '0);
         e.n = e.f[N-1];
      end
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Monitor / scoreboard
   always @(negedge clk) begin
      if (!rst) begin
         if (o_done && o_busy) begin
            checks++;
            errors++;
            $display("FAIL done_with_busy: done=1 busy=1 expected done=0 while busy");
         end
         if (o_done) begin
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_done: done=1 with empty scoreboard expected done=0");
            end else begin
               exp_t e;
               e = q.pop_front();
               if ({o_f, o_f_hi, o_cout, o_v, o_z, o_n} !== e) begin
                  errors++;
                  $display("FAIL result: got f=%h fhi=%h c=%b v=%b z=%b n=%b expected f=%h fhi=%h c=%b v=%b z=%b n=%b",
                           o_f, o_f_hi, o_cout, o_v, o_z, o_n, e.f, e.fhi, e.cout, e.v, e.z, e.n);
               end
            end
         end
      end
   end

   // Issue one op that will be accepted; returns 1 ns after the completing edge
   task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic cin, input logic [3:0] ctrl);
      int cnt;
      i_a = a; i_b = b; i_cin = cin; i_ctrl = ctrl; i_start = 1'b1;
      q.push_back(model(a, b, cin, ctrl));
      @(posedge clk); #1;
      i_start = 1'b0;
      if (ctrl == 4'b1000 && !cin) begin
         chk("mul_busy_set", 32'(o_busy), 32'd1);
         i_a = N'($urandom); i_b = N'($urandom);
         cnt = 0;
         while (o_busy && cnt < 4*N) begin
            @(posedge clk); #1;
            cnt++;
         end
         chk("mul_busy_cycles", 32'(cnt), 32'(N));
         chk("mul_done", 32'(o_done), 32'd1);
      end else begin
         chk("single_busy", 32'(o_busy), 32'd0);
         chk("single_done", 32'(o_done), 32'd1);
      end
   endtask

   task automatic mul_with_intrusions(input logic [N-1:0] a, input logic [N-1:0] b);
      exp_t e;
      e = model(a, b, 1'b0, 4'b1000);
      i_a = a; i_b = b; i_cin = 1'b0; i_ctrl = 4'b1000; i_start = 1'b1;
      q.push_back(e);
      @(posedge clk); #1;
      // Iteration i drives what edge k+i samples; ADD requests at k+2, k+5, k+N
      for (int i = 1; i <= N; i++) begin
         if (i == 2 || i == 5 || i == N) begin
            i_a = 8'h03; i_b = 8'h04; i_cin = 1'b0; i_ctrl = 4'b0000; i_start = 1'b1;
         end else begin
            i_a = N'($urandom); i_b = N'($urandom); i_start = 1'b0;
         end
         @(posedge clk); #1;
      end
      i_start = 1'b0;
      chk("intr_done", 32'(o_done), 32'd1);
      chk("intr_busy", 32'(o_busy), 32'd0);
      @(posedge clk); #1;
      chk("intr_no_add_done", 32'(o_done), 32'd0);
      chk("intr_f_held", 32'(o_f), 32'(e.f));
      chk("intr_fhi_held", 32'(o_f_hi), 32'(e.fhi));
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_f"}, 32'(o_f), 32'd0);
      chk({tag, "_fhi"}, 32'(o_f_hi), 32'd0);
      chk({tag, "_cout"}, 32'(o_cout), 32'd0);
      chk({tag, "_v"}, 32'(o_v), 32'd0);
      chk({tag, "_z"}, 32'(o_z), 32'd0);
      chk({tag, "_n"}, 32'(o_n), 32'd0);
      chk({tag, "_busy"}, 32'(o_busy), 32'd0);
      chk({tag, "_done"}, 32'(o_done), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] c;
      rst = 1'b1; i_start = 1'b0; i_a = '0; i_b = '0; i_cin = 1'b0; i_ctrl = '0;
      repeat (3) @(posedge clk);
      #1;
      chk_all_zero("reset");
      rst = 1'b0;
      @(posedge clk); #1;

      // Directed ops
      do_op(8'h7F, 8'h01, 1'b0, 4'b0000);   // ADD overflow
      chk("add_f", 32'(o_f), 32'h80);
      chk("add_v", 32'(o_v), 32'd1);
      do_op(8'h05, 8'h05, 1'b1, 4'b0000);   // SUB to zero
      do_op(8'h80, 8'h03, 1'b1, 4'b0100);   // LSR
      do_op(8'h81, 8'h01, 1'b1, 4'b1000);   // ROL
      do_op(8'h80, 8'h02, 1'b1, 4'b1001);   // ASR
      do_op(8'hFF, 8'hFF, 1'b0, 4'b1000);   // MUL
      chk("mulff_fhi", 32'(o_f_hi), 32'hFE);
      chk("mulff_f", 32'(o_f), 32'h01);
      do_op(8'h00, 8'h37, 1'b0, 4'b1000);   // MUL to zero
      chk("mul0_z", 32'(o_z), 32'd1);
      mul_with_intrusions(8'hC3, 8'h5A);
      do_op(8'hF0, 8'h0F, 1'b0, 4'b0001);   // OR, then AND on the next edge
      do_op(8'hF0, 8'h0F, 1'b0, 4'b0010);
      chk("and_z", 32'(o_z), 32'd1);

      // Reset in the middle of a multiply
      i_a = 8'hA5; i_b = 8'h3C; i_cin = 1'b0; i_ctrl = 4'b1000; i_start = 1'b1;
      @(posedge clk); #1;
      i_start = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk_all_zero("midrst");
      q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (N + 3) @(posedge clk);   // monitor flags any stray done
      #1;
      do_op(8'h03, 8'h04, 1'b0, 4'b0000);
      chk("post_rst_add", 32'(o_f), 32'h07);

      // Randomised ops, MUL weighted up, occasional idle gaps
      for (int k = 0; k < 150; k++) begin
         c = ($urandom_range(0, 4) == 0) ? 4'b1000 : 4'($urandom_range(0, 15));
         do_op(N'($urandom), N'($urandom), 1'($urandom), c);
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
         end
      end

      repeat (3) @(posedge clk);
      #1;
      chk("scoreboard_empty", 32'(q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/seq_alu_core.md
# seq_alu_core

Registered, parametrised successor to the datapath's combinational ALU. Keeps the 16-entry ctrl/cin function table, adds a fourth ctrl bit for extended operations: rotate, arithmetic shift right, and an iterative N-cycle unsigned multiply. A start/busy/done handshake and registered flags let the control unit issue an operation and stall only on multi-cycle ops.

## Interface
- N, 8, data width
- M, 3, shift-amount width, M = log2(N)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; accepted on a rising edge when busy=0
- a  in  N  operand A, captured on accept
- b  in  N  operand B, captured on accept
- cin  in  1  carry in / variant select, captured on accept
- ctrl  in  4  operation select, captured on accept
- f  out  N  result (low half of product for MUL)
- f_hi  out  N  high half of product for MUL; 0 for all other ops
- cout  out  1  adder carry out
- v  out  1  signed overflow
- z  out  1  result is zero
- n  out  1  result sign
- busy  out  1  multi-cycle op in progress
- done  out  1  one-cycle pulse: f/flags valid for the op just completed

## Operation
- ctrl[3]=0 uses the legacy table (ctrl[2:0], cin):
  - 000: A+B / A-B (A+~B+1)
  - 001: A|B / A|~B; 101: same
  - 010: A&B / A&~B; 110: same
  - 011: ~A / ~B
  - 100: LSL A by B[M-1:0] / LSR A by B[M-1:0], zero fill
  - 111: pass A / pass B
- ctrl[3]=1: 1000 cin0 MUL (unsigned A*B, 2N-bit result {f_hi,f}); 1000 cin1 ROL A by B[M-1:0]; 1001 cin0 ROR; 1001 cin1 ASR (sign fill); other codes: f=0, flags per rules below.
- Shift amount is always B[M-1:0]; amount 0 passes A unchanged.
- cout: adder carry for ctrl=0000 only, else 0. For subtract, cout=1 means no borrow.
- v: carry[N-1] XOR carry[N] for ctrl=0000 only, else 0.
- z: 1 when f==0. For MUL, 1 when {f_hi,f}==0.
- n: f[N-1]. For MUL, f_hi[N-1].
- FSM states:
  - IDLE: on accepted start with a single-cycle op, load f/f_hi/flags, pulse done, stay IDLE. On accepted MUL, load the multiplicand, multiplier and a cleared 2N accumulator, set busy, go to MUL.
  - MUL: a 3-bit-agnostic counter runs N iterations, one shift-add step per edge. On the final step, load {f_hi,f} and flags, clear busy, pulse done, go to IDLE.
- start while busy=1 is ignored: not queued, no effect.
- f, f_hi and flags hold their last values until the next op completes.
- Operand inputs may change freely after accept.

## Timing
- Reset (async, any time): f=0, f_hi=0, cout=0, v=0, z=0, n=0, busy=0, done=0, state IDLE, counter 0.
- Reset during MUL aborts it. No done is produced and outputs read 0.
- Single-cycle ops: accepted at edge k. Results valid and done=1 from edge k to edge k+1. busy stays 0.
- Back-to-back single-cycle ops are accepted every cycle, with done high continuously.
- MUL: accepted at edge k. busy=1 from edge k to edge k+N. Results and done=1 from edge k+N to edge k+N+1.
- A start present at edge k+N (busy still 1) is ignored. The earliest new accept is edge k+N+1.
- done is never high while busy is high.

## Test plan
- ADD, N=8: a=0x7F, b=0x01, cin=0, ctrl=0000 -> after 1 edge, f=0x80, v=1, n=1, cout=0, z=0, done for 1 cycle.
- SUB: a=0x05, b=0x05, cin=1, ctrl=0000 -> f=0x00, z=1, cout=1, v=0. Then LSR a=0x80, b=3 -> f=0x10, cout=0; ROL a=0x81, b=1 -> f=0x03; ASR a=0x80, b=2 -> f=0xE0.
- MUL: a=0xFF, b=0xFF -> busy=1 for exactly 8 cycles, then f_hi=0xFE, f=0x01, n=1, z=0, done pulse. MUL 0x00*0x37 -> z=1.
- Start pulsed with ADD operands at cycles 2 and 5 of a MUL -> both ignored. MUL result is unaffected and f is not changed by the ADD.
- rst asserted mid-cycle at MUL iteration 4 -> all outputs 0 immediately, no done afterwards. A fresh ADD 0x03+0x04 after release gives f=0x07.
- Back-to-back OR (0xF0|0x0F) then AND (0xF0&0x0F) on consecutive edges -> f=0xFF then f=0x00 with z=1, done high for both cycles.
